// File: rtl/stopwatch_pkg.sv
// Shared definitions for the MM:SS stopwatch: FSM state encoding and default digit moduli.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } sw_state_t;

    localparam int NUM_DIGITS   = 4;
    localparam int DIGIT_W_DEF  = 4;
    localparam int SEC_LO_N_DEF = 10;
    localparam int SEC_HI_N_DEF = 6;
    localparam int MIN_LO_N_DEF = 10;
    localparam int MIN_HI_N_DEF = 6;

    // Time advances in RUN and in LAP (LAP only freezes the display).
    function automatic logic is_counting(input sw_state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_mod_counter.sv
// Modulo-N digit counter with synchronous clear (priority over enable) and a terminal-count flag.
module mod_counter #(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = (count_reg == LAST) ? '0 : count_reg + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign tc    = (count_reg == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap/clear FSM over four cascaded digit counters,
// with a lap snapshot shown while in LAP and a sticky 59:59 -> 00:00 rollover flag.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SEC_LO_N = SEC_LO_N_DEF,
    parameter int SEC_HI_N = SEC_HI_N_DEF,
    parameter int MIN_LO_N = MIN_LO_N_DEF,
    parameter int MIN_HI_N = MIN_HI_N_DEF,
    parameter int W        = DIGIT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         start_stop,
    input  logic         lap,
    input  logic         clear,
    output logic [W-1:0] disp0,
    output logic [W-1:0] disp1,
    output logic [W-1:0] disp2,
    output logic [W-1:0] disp3,
    output logic         running,
    output logic         lap_active,
    output logic         wrapped
);

    localparam int MODULI [NUM_DIGITS] = '{SEC_LO_N, SEC_HI_N, MIN_LO_N, MIN_HI_N};

    sw_state_t state_reg;
    sw_state_t state_next;
    logic      snap_load;
    logic      digit_clr;
    logic      cnt_en;
    logic      rollover;
    logic      wrapped_reg;

    logic [NUM_DIGITS-1:0] digit_en;
    logic [NUM_DIGITS-1:0] digit_tc;
    logic [W-1:0]          digit    [NUM_DIGITS];
    logic [W-1:0]          disp_mux [NUM_DIGITS];

    // Priority clear > start_stop > lap, but only among pulses valid in the current state.
    always_comb begin
        state_next = state_reg;
        snap_load  = 1'b0;
        digit_clr  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start_stop) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (start_stop) begin
                    state_next = ST_PAUSE;
                end else if (lap) begin
                    state_next = ST_LAP;
                    snap_load  = 1'b1;
                end
            end
            ST_LAP: begin
                if (start_stop)  state_next = ST_PAUSE;
                else if (lap)    state_next = ST_RUN;
            end
            ST_PAUSE: begin
                if (clear) begin
                    state_next = ST_IDLE;
                    digit_clr  = 1'b1;
                end else if (start_stop) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counting is decided by the state before the edge, so a stopping pulse still lets this tick count.
    assign cnt_en   = tick && is_counting(state_reg);
    assign rollover = cnt_en && (&digit_tc);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam logic [NUM_DIGITS-1:0] LOWER = NUM_DIGITS'((1 << gi) - 1);

            logic [W-1:0] snap_reg;

            // A digit advances only when every lower digit is at its terminal value.
            assign digit_en[gi] = cnt_en && ((digit_tc & LOWER) == LOWER);

            mod_counter #(
                .N (MODULI[gi]),
                .W (W)
            ) u_counter (
                .clk   (clk),
                .rst   (rst),
                .clr   (digit_clr),
                .en    (digit_en[gi]),
                .count (digit[gi]),
                .tc    (digit_tc[gi])
            );

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    snap_reg <= '0;
                end else if (snap_load) begin
                    snap_reg <= digit[gi];
                end
            end

            assign disp_mux[gi] = (state_reg == ST_LAP) ? snap_reg : digit[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrapped_reg <= 1'b0;
        end else if (digit_clr) begin
            wrapped_reg <= 1'b0;
        end else if (rollover) begin
            wrapped_reg <= 1'b1;
        end
    end

    assign disp0      = disp_mux[0];
    assign disp1      = disp_mux[1];
    assign disp2      = disp_mux[2];
    assign disp3      = disp_mux[3];
    assign running    = is_counting(state_reg);
    assign lap_active = (state_reg == ST_LAP);
    assign wrapped    = wrapped_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random pulses,
// compared every cycle against an elapsed-seconds reference model.
module tb_stopwatch_ctrl;

    localparam int W        = 4;
    localparam int SEC_LO_N = 10;
    localparam int SEC_HI_N = 6;
    localparam int MIN_LO_N = 10;
    localparam int MIN_HI_N = 6;
    localparam int TOTAL    = SEC_LO_N * SEC_HI_N * MIN_LO_N * MIN_HI_N;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic         start_stop;
    logic         lap;
    logic         clear;
    logic [W-1:0] disp0;
    logic [W-1:0] disp1;
    logic [W-1:0] disp2;
    logic [W-1:0] disp3;
    logic         running;
    logic         lap_active;
    logic         wrapped;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .SEC_LO_N (SEC_LO_N),
        .SEC_HI_N (SEC_HI_N),
        .MIN_LO_N (MIN_LO_N),
        .MIN_HI_N (MIN_HI_N),
        .W        (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .disp0      (disp0),
        .disp1      (disp1),
        .disp2      (disp2),
        .disp3      (disp3),
        .running    (running),
        .lap_active (lap_active),
        .wrapped    (wrapped)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: elapsed time as a plain seconds count, digits derived arithmetically.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_LAP} m_state_t;
    m_state_t m_st;
    int       m_total;
    int       m_snap;
    bit       m_wrapped;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int digit_of(input int val, input int idx);
        case (idx)
            0:       return val % SEC_LO_N;
            1:       return (val / SEC_LO_N) % SEC_HI_N;
            2:       return (val / (SEC_LO_N * SEC_HI_N)) % MIN_LO_N;
            default: return (val / (SEC_LO_N * SEC_HI_N * MIN_LO_N)) % MIN_HI_N;
        endcase
    endfunction

    function automatic void model_reset();
        m_st      = M_IDLE;
        m_total   = 0;
        m_snap    = 0;
        m_wrapped = 0;
    endfunction

    function automatic void model_step(input bit t, input bit s, input bit l, input bit c);
        bit counting;
        counting = t && (m_st == M_RUN || m_st == M_LAP);
        case (m_st)
            M_IDLE:  if (s) m_st = M_RUN;
            M_RUN: begin
                if (s) m_st = M_PAUSE;
                else if (l) begin
                    m_snap = m_total;
                    m_st   = M_LAP;
                end
            end
            M_LAP: begin
                if (s)      m_st = M_PAUSE;
                else if (l) m_st = M_RUN;
            end
            default: begin
                if (c) begin
                    m_st      = M_IDLE;
                    m_total   = 0;
                    m_wrapped = 0;
                end else if (s) m_st = M_RUN;
            end
        endcase
        if (counting) begin
            m_total = m_total + 1;
            if (m_total == TOTAL) begin
                m_total   = 0;
                m_wrapped = 1;
            end
        end
    endfunction

    task automatic compare_model();
        int shown;
        shown = (m_st == M_LAP) ? m_snap : m_total;
        check_eq("disp0", int'(disp0), digit_of(shown, 0));
        check_eq("disp1", int'(disp1), digit_of(shown, 1));
        check_eq("disp2", int'(disp2), digit_of(shown, 2));
        check_eq("disp3", int'(disp3), digit_of(shown, 3));
        check_eq("running", int'(running), int'(m_st == M_RUN || m_st == M_LAP));
        check_eq("lap_active", int'(lap_active), int'(m_st == M_LAP));
        check_eq("wrapped", int'(wrapped), int'(m_wrapped));
    endtask

    task automatic check_disp(input string tag, input int d3, input int d2, input int d1, input int d0);
        check_eq({tag, "_d3"}, int'(disp3), d3);
        check_eq({tag, "_d2"}, int'(disp2), d2);
        check_eq({tag, "_d1"}, int'(disp1), d1);
        check_eq({tag, "_d0"}, int'(disp0), d0);
    endtask

    // One clock cycle: drive at negedge, sample 1 ns after the rising edge.
    task automatic cycle(input bit t, input bit s, input bit l, input bit c);
        @(negedge clk);
        tick = t; start_stop = s; lap = l; clear = c;
        @(posedge clk);
        model_step(t, s, l, c);
        #1;
        compare_model();
        if (s || l || c)
            $display("txn t=%0t tick=%0b ss=%0b lap=%0b clr=%0b -> disp %0d%0d:%0d%0d run=%0b lap=%0b wrap=%0b",
                     $time, t, s, l, c, disp3, disp2, disp1, disp0, running, lap_active, wrapped);
        tick = 0; start_stop = 0; lap = 0; clear = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted between clock edges; outputs must drop without waiting for an edge.
    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_model();
        check_disp("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        compare_model();
        rst = 1'b1;
        $display("txn t=%0t async reset released", $time);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; tick = 0; start_stop = 0; lap = 0; clear = 0;
        model_reset();
        #7;
        compare_model();
        check_disp("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // Start, 75 ticks -> 01:15, then pause freezes the count.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(75);
        check_disp("run75", 0, 1, 1, 5);
        check_eq("run75_running", int'(running), 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        check_disp("paused", 0, 1, 1, 5);
        check_eq("paused_running", int'(running), 0);

        // Lap coinciding with a tick freezes the pre-increment value.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(9);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("lap_active", int'(lap_active), 1);
        check_disp("lap_frozen", 0, 0, 0, 9);
        ticks(2);
        check_disp("lap_still", 0, 0, 0, 9);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_disp("lap_exit", 0, 0, 1, 2);

        // Run to 59:59 and roll over.
        ticks(TOTAL - 1 - m_total);
        check_disp("at_5959", 5, 9, 5, 9);
        check_eq("pre_wrap", int'(wrapped), 0);
        ticks(1);
        check_disp("rollover", 0, 0, 0, 0);
        check_eq("wrapped_set", int'(wrapped), 1);
        check_eq("wrap_running", int'(running), 1);
        ticks(3);
        check_eq("wrapped_sticky", int'(wrapped), 1);

        // Clear ignored in RUN, honoured in PAUSE.
        ticks(207 - m_total);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_disp("clr_in_run", 0, 3, 2, 7);
        check_eq("clr_in_run_wrap", int'(wrapped), 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check_disp("clr_in_pause", 0, 0, 0, 0);
        check_eq("clr_wrap", int'(wrapped), 0);
        check_eq("clr_running", int'(running), 0);

        // Coincident pulses: clear beats start_stop in PAUSE; start_stop beats lap in RUN.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_disp("ss_tick_run", 0, 0, 0, 5);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("clr_ss_running", int'(running), 0);
        check_disp("clr_ss", 0, 0, 0, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("ss_lap_lapact", int'(lap_active), 0);
        check_eq("ss_lap_running", int'(running), 0);

        // Random pulses against the model.
        for (int i = 0; i < 2500; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 7) == 0));
        end

        // Async reset in LAP at 12:34, then a stray tick in IDLE must not count.
        async_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(754);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_disp("lap_1234", 1, 2, 3, 4);
        check_eq("lap_1234_act", int'(lap_active), 1);
        async_reset();
        check_eq("post_rst_running", int'(running), 0);
        ticks(1);
        check_disp("idle_tick", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
